// File: rtl/rocket_axi_pkg.sv
// Shared AXI4 encodings and FSM state type
// for the simple-port to AXI4 bridge.
package rocket_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [3:0] CACHE_MOD = 4'b0010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } state_e;

  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/rocket_mem_to_axi_if.sv
// AXI4 master-side bundle (axi4_mem_0 naming)
// shared by the bridge and its slave.
interface rocket_mem_to_axi_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                    axi4_mem_0_bits_aw_valid;
  logic                    axi4_mem_0_bits_aw_ready;
  logic [ID_WIDTH-1:0]     axi4_mem_0_bits_aw_id;
  logic [ADDR_WIDTH-1:0]   axi4_mem_0_bits_aw_addr;
  logic [7:0]              axi4_mem_0_bits_aw_len;
  logic [2:0]              axi4_mem_0_bits_aw_size;
  logic [1:0]              axi4_mem_0_bits_aw_burst;
  logic                    axi4_mem_0_bits_aw_lock;
  logic [3:0]              axi4_mem_0_bits_aw_cache;
  logic [2:0]              axi4_mem_0_bits_aw_prot;
  logic [3:0]              axi4_mem_0_bits_aw_qos;

  logic                    axi4_mem_0_bits_w_valid;
  logic                    axi4_mem_0_bits_w_ready;
  logic [DATA_WIDTH-1:0]   axi4_mem_0_bits_w_data;
  logic [DATA_WIDTH/8-1:0] axi4_mem_0_bits_w_strb;
  logic                    axi4_mem_0_bits_w_last;

  logic                    axi4_mem_0_bits_b_valid;
  logic                    axi4_mem_0_bits_b_ready;
  logic [ID_WIDTH-1:0]     axi4_mem_0_bits_b_id;
  logic [1:0]              axi4_mem_0_bits_b_resp;

  logic                    axi4_mem_0_bits_ar_valid;
  logic                    axi4_mem_0_bits_ar_ready;
  logic [ID_WIDTH-1:0]     axi4_mem_0_bits_ar_id;
  logic [ADDR_WIDTH-1:0]   axi4_mem_0_bits_ar_addr;
  logic [7:0]              axi4_mem_0_bits_ar_len;
  logic [2:0]              axi4_mem_0_bits_ar_size;
  logic [1:0]              axi4_mem_0_bits_ar_burst;
  logic                    axi4_mem_0_bits_ar_lock;
  logic [3:0]              axi4_mem_0_bits_ar_cache;
  logic [2:0]              axi4_mem_0_bits_ar_prot;
  logic [3:0]              axi4_mem_0_bits_ar_qos;

  logic                    axi4_mem_0_bits_r_valid;
  logic                    axi4_mem_0_bits_r_ready;
  logic [ID_WIDTH-1:0]     axi4_mem_0_bits_r_id;
  logic [DATA_WIDTH-1:0]   axi4_mem_0_bits_r_data;
  logic [1:0]              axi4_mem_0_bits_r_resp;
  logic                    axi4_mem_0_bits_r_last;

  modport master (
    output axi4_mem_0_bits_aw_valid, axi4_mem_0_bits_aw_id,
    output axi4_mem_0_bits_aw_addr, axi4_mem_0_bits_aw_len,
    output axi4_mem_0_bits_aw_size, axi4_mem_0_bits_aw_burst,
    output axi4_mem_0_bits_aw_lock, axi4_mem_0_bits_aw_cache,
    output axi4_mem_0_bits_aw_prot, axi4_mem_0_bits_aw_qos,
    input  axi4_mem_0_bits_aw_ready,
    output axi4_mem_0_bits_w_valid, axi4_mem_0_bits_w_data,
    output axi4_mem_0_bits_w_strb, axi4_mem_0_bits_w_last,
    input  axi4_mem_0_bits_w_ready,
    input  axi4_mem_0_bits_b_valid, axi4_mem_0_bits_b_id,
    input  axi4_mem_0_bits_b_resp,
    output axi4_mem_0_bits_b_ready,
    output axi4_mem_0_bits_ar_valid, axi4_mem_0_bits_ar_id,
    output axi4_mem_0_bits_ar_addr, axi4_mem_0_bits_ar_len,
    output axi4_mem_0_bits_ar_size, axi4_mem_0_bits_ar_burst,
    output axi4_mem_0_bits_ar_lock, axi4_mem_0_bits_ar_cache,
    output axi4_mem_0_bits_ar_prot, axi4_mem_0_bits_ar_qos,
    input  axi4_mem_0_bits_ar_ready,
    input  axi4_mem_0_bits_r_valid, axi4_mem_0_bits_r_id,
    input  axi4_mem_0_bits_r_data, axi4_mem_0_bits_r_resp,
    input  axi4_mem_0_bits_r_last,
    output axi4_mem_0_bits_r_ready
  );

  modport slave (
    input  axi4_mem_0_bits_aw_valid, axi4_mem_0_bits_aw_id,
    input  axi4_mem_0_bits_aw_addr, axi4_mem_0_bits_aw_len,
    input  axi4_mem_0_bits_aw_size, axi4_mem_0_bits_aw_burst,
    input  axi4_mem_0_bits_aw_lock, axi4_mem_0_bits_aw_cache,
    input  axi4_mem_0_bits_aw_prot, axi4_mem_0_bits_aw_qos,
    output axi4_mem_0_bits_aw_ready,
    input  axi4_mem_0_bits_w_valid, axi4_mem_0_bits_w_data,
    input  axi4_mem_0_bits_w_strb, axi4_mem_0_bits_w_last,
    output axi4_mem_0_bits_w_ready,
    output axi4_mem_0_bits_b_valid, axi4_mem_0_bits_b_id,
    output axi4_mem_0_bits_b_resp,
    input  axi4_mem_0_bits_b_ready,
    input  axi4_mem_0_bits_ar_valid, axi4_mem_0_bits_ar_id,
    input  axi4_mem_0_bits_ar_addr, axi4_mem_0_bits_ar_len,
    input  axi4_mem_0_bits_ar_size, axi4_mem_0_bits_ar_burst,
    input  axi4_mem_0_bits_ar_lock, axi4_mem_0_bits_ar_cache,
    input  axi4_mem_0_bits_ar_prot, axi4_mem_0_bits_ar_qos,
    output axi4_mem_0_bits_ar_ready,
    output axi4_mem_0_bits_r_valid, axi4_mem_0_bits_r_id,
    output axi4_mem_0_bits_r_data, axi4_mem_0_bits_r_resp,
    output axi4_mem_0_bits_r_last,
    input  axi4_mem_0_bits_r_ready
  );
endinterface

// File: rtl/rocket_mem_to_axi.sv
// Simple request/grant memory port to single-beat
// AXI4 master bridge, one transaction in flight.
module rocket_mem_to_axi
  import rocket_axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                    clock,
  input  logic                    reset_wire_reset_n,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  rocket_mem_to_axi_if.master     axi
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    aw_done_q, w_done_q;
  logic                    rvalid_q, err_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_bad, r_bad;

  assign aw_hs = axi.axi4_mem_0_bits_aw_valid
               & axi.axi4_mem_0_bits_aw_ready;
  assign w_hs  = axi.axi4_mem_0_bits_w_valid
               & axi.axi4_mem_0_bits_w_ready;
  assign b_hs  = axi.axi4_mem_0_bits_b_valid
               & axi.axi4_mem_0_bits_b_ready;
  assign ar_hs = axi.axi4_mem_0_bits_ar_valid
               & axi.axi4_mem_0_bits_ar_ready;
  // a beat without r_last is not a completion
  assign r_hs  = axi.axi4_mem_0_bits_r_valid
               & axi.axi4_mem_0_bits_r_ready
               & axi.axi4_mem_0_bits_r_last;

  assign b_bad = (axi.axi4_mem_0_bits_b_resp != RESP_OKAY)
               | (axi.axi4_mem_0_bits_b_id != AXI_ID);
  assign r_bad = (axi.axi4_mem_0_bits_r_resp != RESP_OKAY)
               | (axi.axi4_mem_0_bits_r_id != AXI_ID);

  always_ff @(posedge clock or negedge reset_wire_reset_n) begin
    if (!reset_wire_reset_n) state_q <= ST_IDLE;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (req_i) state_d = we_i ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs))
          state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = ST_IDLE;
      ST_RD_REQ:  if (ar_hs) state_d = ST_RD_RESP;
      ST_RD_RESP: if (r_hs) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // gnt is forced low while reset is held
  always_comb begin
    gnt_o = reset_wire_reset_n & req_i & (state_q == ST_IDLE);
    axi.axi4_mem_0_bits_aw_valid = (state_q == ST_WR_REQ) & ~aw_done_q;
    axi.axi4_mem_0_bits_w_valid  = (state_q == ST_WR_REQ) & ~w_done_q;
    axi.axi4_mem_0_bits_b_ready  = (state_q == ST_WR_RESP);
    axi.axi4_mem_0_bits_ar_valid = (state_q == ST_RD_REQ);
    axi.axi4_mem_0_bits_r_ready  = (state_q == ST_RD_RESP);
  end

  assign axi.axi4_mem_0_bits_aw_id    = AXI_ID;
  assign axi.axi4_mem_0_bits_aw_addr  = addr_q;
  assign axi.axi4_mem_0_bits_aw_len   = 8'd0;
  assign axi.axi4_mem_0_bits_aw_size  = axi_size(DATA_WIDTH);
  assign axi.axi4_mem_0_bits_aw_burst = BURST_INCR;
  assign axi.axi4_mem_0_bits_aw_lock  = 1'b0;
  assign axi.axi4_mem_0_bits_aw_cache = CACHE_MOD;
  assign axi.axi4_mem_0_bits_aw_prot  = 3'd0;
  assign axi.axi4_mem_0_bits_aw_qos   = 4'd0;
  assign axi.axi4_mem_0_bits_w_data   = wdata_q;
  assign axi.axi4_mem_0_bits_w_strb   = be_q;
  assign axi.axi4_mem_0_bits_w_last   = 1'b1;
  assign axi.axi4_mem_0_bits_ar_id    = AXI_ID;
  assign axi.axi4_mem_0_bits_ar_addr  = addr_q;
  assign axi.axi4_mem_0_bits_ar_len   = 8'd0;
  assign axi.axi4_mem_0_bits_ar_size  = axi_size(DATA_WIDTH);
  assign axi.axi4_mem_0_bits_ar_burst = BURST_INCR;
  assign axi.axi4_mem_0_bits_ar_lock  = 1'b0;
  assign axi.axi4_mem_0_bits_ar_cache = CACHE_MOD;
  assign axi.axi4_mem_0_bits_ar_prot  = 3'd0;
  assign axi.axi4_mem_0_bits_ar_qos   = 4'd0;

  always_ff @(posedge clock or negedge reset_wire_reset_n) begin
    if (!reset_wire_reset_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (gnt_o) begin
      addr_q  <= addr_i;
      be_q    <= be_i;
      wdata_q <= wdata_i;
    end
  end

  always_ff @(posedge clock or negedge reset_wire_reset_n) begin
    if (!reset_wire_reset_n) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (state_q != ST_WR_REQ) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_wire_reset_n) begin
    if (!reset_wire_reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= b_hs | r_hs;
      if (r_hs) begin
        rdata_q <= axi.axi4_mem_0_bits_r_data;
        err_q   <= r_bad;
      end else if (b_hs) begin
        rdata_q <= '0;
        err_q   <= b_bad;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_rocket_mem_to_axi.sv
// Directed bench for rocket_mem_to_axi: one task
// per scenario, cycle-exact checks at negedge.
module tb_rocket_mem_to_axi;
  import rocket_axi_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, we, gnt, rvalid, err;
  logic [31:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata, rdata;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rocket_mem_to_axi_if #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)
  ) axi ();

  rocket_mem_to_axi #(
    .ID_WIDTH(4), .ADDR_WIDTH(32),
    .DATA_WIDTH(64), .AXI_ID(4'd0)
  ) dut (
    .clock(clock),
    .reset_wire_reset_n(rst_n),
    .req_i(req),
    .gnt_o(gnt),
    .we_i(we),
    .addr_i(addr),
    .be_i(be),
    .wdata_i(wdata),
    .rvalid_o(rvalid),
    .rdata_o(rdata),
    .err_o(err),
    .axi(axi)
  );

  // advance to the next negedge, then settle
  task automatic nxt();
    @(negedge clock);
    #1;
  endtask

  task automatic slave_idle();
    axi.axi4_mem_0_bits_aw_ready = 1'b0;
    axi.axi4_mem_0_bits_w_ready  = 1'b0;
    axi.axi4_mem_0_bits_b_valid  = 1'b0;
    axi.axi4_mem_0_bits_b_id     = 4'd0;
    axi.axi4_mem_0_bits_b_resp   = 2'd0;
    axi.axi4_mem_0_bits_ar_ready = 1'b0;
    axi.axi4_mem_0_bits_r_valid  = 1'b0;
    axi.axi4_mem_0_bits_r_id     = 4'd0;
    axi.axi4_mem_0_bits_r_data   = 64'd0;
    axi.axi4_mem_0_bits_r_resp   = 2'd0;
    axi.axi4_mem_0_bits_r_last   = 1'b0;
  endtask

  task automatic test_reset();
    req = 1'b1; we = 1'b1; addr = 32'h0;
    be = 8'h0; wdata = 64'h0;
    slave_idle();
    axi.axi4_mem_0_bits_b_valid = 1'b1;
    #3;
    checks++;
    if (gnt !== 1'b0) begin
      failures++;
      $display("FAIL rst_gnt got %b exp 0", gnt);
    end
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 64'd0) begin
      failures++;
      $display("FAIL rst_outs got %b %b %h exp 0", rvalid, err, rdata);
    end
    checks++;
    if (axi.axi4_mem_0_bits_aw_valid !== 1'b0 ||
        axi.axi4_mem_0_bits_b_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_axi got aw=%b bready=%b exp 0",
               axi.axi4_mem_0_bits_aw_valid,
               axi.axi4_mem_0_bits_b_ready);
    end
    req = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    nxt();
    nxt();
    // stray b_valid while idle must not complete anything
    checks++;
    if (rvalid !== 1'b0 || axi.axi4_mem_0_bits_b_ready !== 1'b0) begin
      failures++;
      $display("FAIL stray_b got rv=%b br=%b exp 0 0",
               rvalid, axi.axi4_mem_0_bits_b_ready);
    end
    axi.axi4_mem_0_bits_b_valid = 1'b0;
  endtask

  task automatic test_write();
    slave_idle();
    axi.axi4_mem_0_bits_aw_ready = 1'b1;
    axi.axi4_mem_0_bits_w_ready  = 1'b1;
    axi.axi4_mem_0_bits_b_valid  = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h8000_0010;
    be = 8'hFF; wdata = 64'hDEAD_BEEF_0123_4567;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      failures++;
      $display("FAIL wr_gnt got %b exp 1", gnt);
    end
    nxt();
    req = 1'b0; addr = 32'h0; wdata = 64'h0;
    #1;
    checks++;
    if (axi.axi4_mem_0_bits_aw_valid !== 1'b1 ||
        axi.axi4_mem_0_bits_w_valid !== 1'b1) begin
      failures++;
      $display("FAIL wr_valid got %b %b exp 1 1",
               axi.axi4_mem_0_bits_aw_valid,
               axi.axi4_mem_0_bits_w_valid);
    end
    checks++;
    if (axi.axi4_mem_0_bits_aw_addr !== 32'h8000_0010 ||
        axi.axi4_mem_0_bits_w_data !== 64'hDEAD_BEEF_0123_4567 ||
        axi.axi4_mem_0_bits_w_strb !== 8'hFF) begin
      failures++;
      $display("FAIL wr_payload got %h %h %h exp 80000010 deadbeef01234567 ff",
               axi.axi4_mem_0_bits_aw_addr,
               axi.axi4_mem_0_bits_w_data,
               axi.axi4_mem_0_bits_w_strb);
    end
    checks++;
    if (axi.axi4_mem_0_bits_aw_size !== 3'd3 ||
        axi.axi4_mem_0_bits_aw_burst !== 2'b01 ||
        axi.axi4_mem_0_bits_aw_cache !== 4'b0010 ||
        axi.axi4_mem_0_bits_aw_len !== 8'd0 ||
        axi.axi4_mem_0_bits_w_last !== 1'b1 ||
        axi.axi4_mem_0_bits_aw_id !== 4'd0) begin
      failures++;
      $display("FAIL wr_const got sz=%0d bu=%0d ca=%0d len=%0d last=%b id=%0d exp 3 1 2 0 1 0",
               axi.axi4_mem_0_bits_aw_size,
               axi.axi4_mem_0_bits_aw_burst,
               axi.axi4_mem_0_bits_aw_cache,
               axi.axi4_mem_0_bits_aw_len,
               axi.axi4_mem_0_bits_w_last,
               axi.axi4_mem_0_bits_aw_id);
    end
    checks++;
    if (axi.axi4_mem_0_bits_b_ready !== 1'b0) begin
      failures++;
      $display("FAIL wr_bready_early got 1 exp 0");
    end
    nxt();
    checks++;
    if (axi.axi4_mem_0_bits_aw_valid !== 1'b0 ||
        axi.axi4_mem_0_bits_b_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_resp got aw=%b br=%b exp 0 1",
               axi.axi4_mem_0_bits_aw_valid,
               axi.axi4_mem_0_bits_b_ready);
    end
    nxt();
    axi.axi4_mem_0_bits_b_valid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 || rdata !== 64'd0) begin
      failures++;
      $display("FAIL wr_done got rv=%b err=%b rd=%h exp 1 0 0",
               rvalid, err, rdata);
    end
    nxt();
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL wr_pulse got %b exp 0", rvalid);
    end
  endtask

  task automatic test_read_stall();
    slave_idle();
    req = 1'b1; we = 1'b0; addr = 32'h8000_0008;
    nxt();
    req = 1'b0; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (axi.axi4_mem_0_bits_ar_valid !== 1'b1 ||
          axi.axi4_mem_0_bits_ar_addr !== 32'h8000_0008 ||
          axi.axi4_mem_0_bits_ar_len !== 8'd0 ||
          axi.axi4_mem_0_bits_ar_size !== 3'd3) begin
        failures++;
        $display("FAIL rd_stall%0d got v=%b a=%h exp 1 80000008",
                 i, axi.axi4_mem_0_bits_ar_valid,
                 axi.axi4_mem_0_bits_ar_addr);
      end
      nxt();
    end
    axi.axi4_mem_0_bits_ar_ready = 1'b1;
    #1;
    checks++;
    if (axi.axi4_mem_0_bits_ar_valid !== 1'b1) begin
      failures++;
      $display("FAIL rd_arhs got 0 exp 1");
    end
    nxt();
    axi.axi4_mem_0_bits_ar_ready = 1'b0;
    axi.axi4_mem_0_bits_r_valid  = 1'b1;
    axi.axi4_mem_0_bits_r_data   = 64'h1122_3344_5566_7788;
    axi.axi4_mem_0_bits_r_last   = 1'b1;
    #1;
    checks++;
    if (axi.axi4_mem_0_bits_ar_valid !== 1'b0 ||
        axi.axi4_mem_0_bits_r_ready !== 1'b1) begin
      failures++;
      $display("FAIL rd_rready got ar=%b rr=%b exp 0 1",
               axi.axi4_mem_0_bits_ar_valid,
               axi.axi4_mem_0_bits_r_ready);
    end
    nxt();
    slave_idle();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 ||
        rdata !== 64'h1122_3344_5566_7788) begin
      failures++;
      $display("FAIL rd_done got rv=%b err=%b rd=%h exp 1 0 1122334455667788",
               rvalid, err, rdata);
    end
    nxt();
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rd_pulse got %b exp 0", rvalid);
    end
  endtask

  task automatic test_w_delay();
    slave_idle();
    axi.axi4_mem_0_bits_aw_ready = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h0000_0100;
    be = 8'h0F; wdata = 64'h55;
    nxt();
    req = 1'b0;
    checks++;
    if (axi.axi4_mem_0_bits_aw_valid !== 1'b1 ||
        axi.axi4_mem_0_bits_w_valid !== 1'b1) begin
      failures++;
      $display("FAIL wd_n1 got %b %b exp 1 1",
               axi.axi4_mem_0_bits_aw_valid,
               axi.axi4_mem_0_bits_w_valid);
    end
    nxt();
    checks++;
    if (axi.axi4_mem_0_bits_aw_valid !== 1'b0 ||
        axi.axi4_mem_0_bits_w_valid !== 1'b1) begin
      failures++;
      $display("FAIL wd_n2 got %b %b exp 0 1",
               axi.axi4_mem_0_bits_aw_valid,
               axi.axi4_mem_0_bits_w_valid);
    end
    nxt();
    nxt();
    axi.axi4_mem_0_bits_w_ready = 1'b1;
    #1;
    checks++;
    if (axi.axi4_mem_0_bits_w_valid !== 1'b1 ||
        axi.axi4_mem_0_bits_w_strb !== 8'h0F ||
        axi.axi4_mem_0_bits_b_ready !== 1'b0) begin
      failures++;
      $display("FAIL wd_n4 got wv=%b strb=%h br=%b exp 1 0f 0",
               axi.axi4_mem_0_bits_w_valid,
               axi.axi4_mem_0_bits_w_strb,
               axi.axi4_mem_0_bits_b_ready);
    end
    nxt();
    axi.axi4_mem_0_bits_w_ready = 1'b0;
    axi.axi4_mem_0_bits_b_valid = 1'b1;
    #1;
    checks++;
    if (axi.axi4_mem_0_bits_w_valid !== 1'b0 ||
        axi.axi4_mem_0_bits_b_ready !== 1'b1) begin
      failures++;
      $display("FAIL wd_n5 got wv=%b br=%b exp 0 1",
               axi.axi4_mem_0_bits_w_valid,
               axi.axi4_mem_0_bits_b_ready);
    end
    nxt();
    slave_idle();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL wd_done got rv=%b err=%b exp 1 0", rvalid, err);
    end
    nxt();
  endtask

  task automatic test_errors();
    slave_idle();
    axi.axi4_mem_0_bits_ar_ready = 1'b1;
    axi.axi4_mem_0_bits_r_valid  = 1'b1;
    axi.axi4_mem_0_bits_r_last   = 1'b1;
    axi.axi4_mem_0_bits_r_resp   = 2'b10;
    axi.axi4_mem_0_bits_r_data   = 64'hA5;
    req = 1'b1; we = 1'b0; addr = 32'h40;
    nxt();
    req = 1'b0;
    nxt();
    nxt();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 64'hA5) begin
      failures++;
      $display("FAIL rd_slverr got rv=%b err=%b rd=%h exp 1 1 a5",
               rvalid, err, rdata);
    end
    slave_idle();
    axi.axi4_mem_0_bits_aw_ready = 1'b1;
    axi.axi4_mem_0_bits_w_ready  = 1'b1;
    axi.axi4_mem_0_bits_b_valid  = 1'b1;
    axi.axi4_mem_0_bits_b_id     = 4'd3;
    req = 1'b1; we = 1'b1; addr = 32'h80;
    nxt();
    req = 1'b0;
    nxt();
    nxt();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b1 || rdata !== 64'd0) begin
      failures++;
      $display("FAIL wr_badid got rv=%b err=%b rd=%h exp 1 1 0",
               rvalid, err, rdata);
    end
    slave_idle();
    nxt();
  endtask

  task automatic test_back_to_back();
    slave_idle();
    axi.axi4_mem_0_bits_aw_ready = 1'b1;
    axi.axi4_mem_0_bits_w_ready  = 1'b1;
    axi.axi4_mem_0_bits_b_valid  = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h200;
    be = 8'hFF; wdata = 64'h1;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gnt1 got %b exp 1", gnt);
    end
    nxt();
    checks++;
    if (gnt !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy got %b exp 0", gnt);
    end
    nxt();
    nxt();
    checks++;
    if (rvalid !== 1'b1 || gnt !== 1'b1) begin
      failures++;
      $display("FAIL b2b_overlap got rv=%b gnt=%b exp 1 1", rvalid, gnt);
    end
    nxt();
    req = 1'b0;
    nxt();
    nxt();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got rv=%b err=%b exp 1 0", rvalid, err);
    end
    slave_idle();
    nxt();
  endtask

  task automatic test_reset_mid();
    slave_idle();
    axi.axi4_mem_0_bits_aw_ready = 1'b1;
    axi.axi4_mem_0_bits_w_ready  = 1'b1;
    req = 1'b1; we = 1'b1; addr = 32'h300;
    nxt();
    nxt();
    checks++;
    if (axi.axi4_mem_0_bits_b_ready !== 1'b1) begin
      failures++;
      $display("FAIL rm_wresp got %b exp 1", axi.axi4_mem_0_bits_b_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (axi.axi4_mem_0_bits_b_ready !== 1'b0 || gnt !== 1'b0 ||
        axi.axi4_mem_0_bits_aw_valid !== 1'b0 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rm_clear got br=%b gnt=%b aw=%b rv=%b exp 0",
               axi.axi4_mem_0_bits_b_ready, gnt,
               axi.axi4_mem_0_bits_aw_valid, rvalid);
    end
    req = 1'b0;
    slave_idle();
    @(negedge clock);
    rst_n = 1'b1;
    axi.axi4_mem_0_bits_ar_ready = 1'b1;
    axi.axi4_mem_0_bits_r_valid  = 1'b1;
    axi.axi4_mem_0_bits_r_last   = 1'b1;
    axi.axi4_mem_0_bits_r_data   = 64'hCAFE_F00D_0000_0042;
    req = 1'b1; we = 1'b0; addr = 32'h8000_0020;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      failures++;
      $display("FAIL rm_gnt got %b exp 1", gnt);
    end
    nxt();
    req = 1'b0;
    nxt();
    nxt();
    checks++;
    if (rvalid !== 1'b1 || err !== 1'b0 ||
        rdata !== 64'hCAFE_F00D_0000_0042) begin
      failures++;
      $display("FAIL rm_read got rv=%b err=%b rd=%h exp 1 0 cafef00d00000042",
               rvalid, err, rdata);
    end
    slave_idle();
    nxt();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_w_delay();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
